crc8_serial_engine: RTL and testbench

- Bit-serial CRC-8 generator/checker, MSB-first, one bit per enabled clock.
- Used by the UART-style frame transmitter: fed the 4-bit frame-size field and then the frame data bytes.
- Its 8-bit result is sent as the frame's CRC byte.
- Also usable on the receive side: a zero_flag reports a clean residue after the CRC bits are shifted in.

---
 rtl/crc8_serial_engine.sv | 68 ++++++
 tb/tb_crc8_serial_engine.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/crc8_serial_engine.sv
// crc8_serial_engine
//   Bit-serial CRC-8 generator/checker, MSB-first, one bit per enabled clock.
//   Feeding a message followed by its own CRC (INIT=0, XOROUT=0) leaves a zero
//   residue, which the receive side observes on zero_flag.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset; loads INIT and zeroes the counter
//   enable     absorb din into the CRC on this edge
//   clear      synchronous restart (higher priority than enable)
//   din        serial data bit, caller presents MSB-first
//   crc_out    register XOR XOROUT (combinational from the register)
//   zero_flag  register equals 8'h00 (combinational from the register)
//   bit_count  bits absorbed since the last reset/clear, wraps modulo 2^CNT_W
module crc8_serial_engine #(
  parameter logic [7:0]  POLY   = 8'h07,
  parameter logic [7:0]  INIT   = 8'h00,
  parameter logic [7:0]  XOROUT = 8'h00,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             din,
  output logic [7:0]       crc_out,
  output logic             zero_flag,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned CrcW = 8;

  logic [CrcW-1:0]  crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fb;

  // Next-state: clear beats enable; din only enters the datapath when enabled
  always_comb begin
    crc_d = crc_q;
    cnt_d = cnt_q;
    fb    = 1'b0;
    if (clear) begin
      crc_d = INIT;
      cnt_d = '0;
    end else if (enable) begin
      fb    = crc_q[CrcW-1] ^ din;
      crc_d = {crc_q[CrcW-2:0], 1'b0} ^ (fb ? POLY : CrcW'(0));
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q <= INIT;
      cnt_q <= '0;
    end else begin
      crc_q <= crc_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs are decoded straight from the register so reset shows immediately
  assign crc_out   = crc_q ^ XOROUT;
  assign zero_flag = (crc_q == CrcW'(0));
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_crc8_serial_engine.sv
// Self-checking bench for crc8_serial_engine (default parameters).
// A reference model keeps the list of absorbed bits and computes the CRC by
// polynomial long division of the augmented message; a per-cycle compare
// process checks all outputs against it, and literal checks pin known values.
module tb_crc8_serial_engine;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             clear;
  logic             din;
  logic [7:0]       crc_out;
  logic             zero_flag;
  logic [CNT_W-1:0] bit_count;

  int n_vec;
  int n_err;

  crc8_serial_engine #(
    .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .din(din),
    .crc_out(crc_out), .zero_flag(zero_flag), .bit_count(bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit msg_q[$];
  int unsigned m_cnt;

  // Remainder of M(x)*x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] model_crc();
    logic [8:0] r;
    r = 9'h000;
    for (int i = 0; i < msg_q.size() + 8; i++) begin
      r = {r[7:0], (i < msg_q.size()) ? logic'(msg_q[i]) : 1'b0};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_q.delete();
      m_cnt = 0;
    end else if (clear) begin
      msg_q.delete();
      m_cnt = 0;
    end else if (enable) begin
      msg_q.push_back(din);
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic [7:0] e;
    e = model_crc();
    chk("crc_out", int'(crc_out), int'(e));
    chk("zero_flag", int'(zero_flag), int'(e == 8'h00));
    chk("bit_count", int'(bit_count), int'(m_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic en, input logic d, input logic clr);
    enable = en;
    din    = d;
    clear  = clr;
    @(posedge clk);
    #1;
  endtask

  // Feed a byte MSB-first; gap idle cycles (random din) before each bit
  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 7; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      step(1'b1, b[i], 1'b0);
    end
  endtask

  task automatic send_check_string(input int gap);
    logic [7:0] s [9];
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int k = 0; k < 9; k++) send_byte(s[k], gap);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
    din    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("reset crc", int'(crc_out), 8'h00);
    chk("reset cnt", int'(bit_count), 0);

    // Single byte 0x01
    send_byte(8'h01, 0);
    chk("byte01 crc", int'(crc_out), 8'h07);
    chk("byte01 cnt", int'(bit_count), 8);

    // Clear then 0x80
    step(1'b0, 1'b0, 1'b1);
    send_byte(8'h80, 0);
    chk("byte80 crc", int'(crc_out), 8'h89);

    // Standard check string, then residue
    step(1'b0, 1'b0, 1'b1);
    send_check_string(0);
    chk("check crc", int'(crc_out), 8'hF4);
    chk("check cnt", int'(bit_count), 72);
    send_byte(8'hF4, 0);
    chk("residue crc", int'(crc_out), 8'h00);
    chk("residue zero", int'(zero_flag), 1);
    chk("residue cnt", int'(bit_count), 80);

    // Idle cycles with X on din must not disturb anything
    step(1'b0, 1'b0, 1'b1);
    send_byte(8'h5A, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'bx, 1'b0);
    chk("idle x cnt", int'(bit_count), 8);

    // Gapped enable: one pulse every 5 cycles gives the same result
    step(1'b0, 1'b0, 1'b1);
    send_check_string(4);
    chk("gapped crc", int'(crc_out), 8'hF4);
    chk("gapped cnt", int'(bit_count), 72);

    // Asynchronous reset mid-message, checked before any clock edge
    step(1'b0, 1'b0, 1'b1);
    send_byte(8'h01, 0);
    send_byte(8'hC3, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async crc", int'(crc_out), 8'h00);
    chk("async zero", int'(zero_flag), 1);
    chk("async cnt", int'(bit_count), 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("hold rst crc", int'(crc_out), 8'h00);
    chk("hold rst cnt", int'(bit_count), 0);
    enable = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    chk("post rst crc", int'(crc_out), 8'h00);
    chk("post rst cnt", int'(bit_count), 0);

    // Clear with enable mid-message, then size field + byte
    send_byte(8'h9C, 0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr+en crc", int'(crc_out), 8'h00);
    chk("clr+en cnt", int'(bit_count), 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    send_byte(8'hA5, 0);
    chk("frame crc", int'(crc_out), 8'h67);
    chk("frame cnt", int'(bit_count), 12);

    step(1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
